// File: rtl/hazard_unit_pkg.sv
// Shared pipeline package for the hazard unit.
// Holds the FSM encoding and mult/div latency defaults.
package hazard_unit_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } hz_state_e;

    localparam int MULDIV_LAT_DEF = 4;
    localparam int BUSY_W         = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Counts clock edges with inc high; sticks at all-ones.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    // next count: hold at all-ones once reached
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {width{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush, mult/div hold.
// Also counts cycles where the PC is frozen.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IFIDusesRt,
    input  logic [4:0]       IDEXRt,
    input  logic             IDEXmemread,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    output logic             pcwrite,
    output logic             ifidwrite,
    output logic             ifidflush,
    output logic             idexwrite,
    output logic             idexbubble,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_state_e         state_q, state_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    logic              load_use;

    // lw in EX whose destination is read by the ID instruction
    always_comb begin
        load_use = IDEXmemread && (IDEXRt != 5'd0) &&
                   ((IDEXRt == IFIDRs) ||
                    (IFIDusesRt && (IDEXRt == IFIDRt)));
    end

    // next-state and control outputs
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        pcwrite     = 1'b1;
        ifidwrite   = 1'b1;
        idexwrite   = 1'b1;
        ifidflush   = 1'b0;
        idexbubble  = 1'b0;
        muldiv_done = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ifidflush  = 1'b1;
                    idexbubble = 1'b1;
                end else if (load_use) begin
                    pcwrite    = 1'b0;
                    ifidwrite  = 1'b0;
                    idexbubble = 1'b1;
                end else if (muldiv_start) begin
                    state_d = BUSY;
                    busy_d  = BUSY_W'(MULDIV_LAT - 1);
                end
            end
            BUSY: begin
                if (busy_q != '0) begin
                    pcwrite   = 1'b0;
                    ifidwrite = 1'b0;
                    idexwrite = 1'b0;
                    busy_d    = busy_q - 1'b1;
                end else begin
                    muldiv_done = 1'b1;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = RUN;
                busy_d  = '0;
            end
        endcase
    end

    // FSM state and busy countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    sat_counter #(
        .width(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (~pcwrite),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
// A second instance with CNT_W=4 exercises counter saturation.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IFIDRs, IFIDRt, IDEXRt;
    logic       IFIDusesRt, IDEXmemread, branch_taken, muldiv_start;

    logic        pcwrite, ifidwrite, ifidflush, idexwrite, idexbubble, muldiv_done;
    logic [15:0] stall_cnt;
    logic        pcwrite4, ifidwrite4, ifidflush4, idexwrite4, idexbubble4, muldiv_done4;
    logic [3:0]  stall_cnt4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .rst(rst),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDusesRt(IFIDusesRt),
        .IDEXRt(IDEXRt), .IDEXmemread(IDEXmemread),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start),
        .pcwrite(pcwrite), .ifidwrite(ifidwrite), .ifidflush(ifidflush),
        .idexwrite(idexwrite), .idexbubble(idexbubble),
        .muldiv_done(muldiv_done), .stall_cnt(stall_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDusesRt(IFIDusesRt),
        .IDEXRt(IDEXRt), .IDEXmemread(IDEXmemread),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start),
        .pcwrite(pcwrite4), .ifidwrite(ifidwrite4), .ifidflush(ifidflush4),
        .idexwrite(idexwrite4), .idexbubble(idexbubble4),
        .muldiv_done(muldiv_done4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pcwrite,ifidwrite,idexwrite,ifidflush,idexbubble,muldiv_done
    function automatic logic [5:0] ctl();
        return {pcwrite, ifidwrite, idexwrite, ifidflush, idexbubble, muldiv_done};
    endfunction

    task automatic idle();
        IFIDRs = 5'd1; IFIDRt = 5'd2; IFIDusesRt = 1'b1;
        IDEXRt = 5'd3; IDEXmemread = 1'b0;
        branch_taken = 1'b0; muldiv_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("reset_ctl", 32'(ctl()), 32'b111000);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_ctl", 32'(ctl()), 32'b111000);

        // load-use on Rs
        @(negedge clk);
        IDEXmemread = 1'b1; IDEXRt = 5'd8; IFIDRs = 5'd8;
        #1;
        chk("load_use_ctl", 32'(ctl()), 32'b001010);
        @(posedge clk); #1;
        chk("load_use_cnt", 32'(stall_cnt), 32'd1);
        @(negedge clk);
        idle();
        #1;
        chk("after_lu_ctl", 32'(ctl()), 32'b111000);

        // r0 never hazards
        IDEXmemread = 1'b1; IDEXRt = 5'd0; IFIDRs = 5'd0;
        #1;
        chk("r0_no_stall", 32'(ctl()), 32'b111000);
        // Rt match ignored when Rt is not read
        IDEXRt = 5'd9; IFIDRt = 5'd9; IFIDRs = 5'd4; IFIDusesRt = 1'b0;
        #1;
        chk("rt_unused_no_stall", 32'(ctl()), 32'b111000);
        // Rt match when read
        IFIDusesRt = 1'b1;
        #1;
        chk("rt_used_stall", 32'(ctl()), 32'b001010);
        @(posedge clk); #1;
        chk("rt_stall_cnt", 32'(stall_cnt), 32'd2);

        // branch beats load-use and muldiv
        @(negedge clk);
        branch_taken = 1'b1; muldiv_start = 1'b1;
        #1;
        chk("branch_ctl", 32'(ctl()), 32'b111110);
        @(posedge clk); #1;
        chk("branch_cnt", 32'(stall_cnt), 32'd2);
        @(negedge clk);
        idle();
        #1;
        chk("branch_no_busy", 32'(ctl()), 32'b111000);

        // mult/div: 3 held cycles then done pulse
        muldiv_start = 1'b1;
        #1;
        chk("md_start_ctl", 32'(ctl()), 32'b111000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            branch_taken = (i == 1);
            IDEXmemread = 1'b1; IDEXRt = 5'd1;
            #1;
            chk($sformatf("md_hold%0d", i), 32'(ctl()), 32'b000000);
        end
        @(negedge clk);
        idle();
        #1;
        chk("md_done", 32'(ctl()), 32'b111001);
        chk("md_cnt", 32'(stall_cnt), 32'd5);
        @(negedge clk);
        #1;
        chk("md_after", 32'(ctl()), 32'b111000);

        // reset during the 2nd busy cycle
        muldiv_start = 1'b1;
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        chk("busy2_hold", 32'(ctl()), 32'b000000);
        rst = 1'b1;
        #1;
        chk("rst_busy_ctl", 32'(ctl()), 32'b111000);
        chk("rst_busy_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("post_rst%0d", i), 32'(ctl()), 32'b111000);
        end
        chk("post_rst_cnt", 32'(stall_cnt), 32'd0);

        // saturation with 4-bit counter over 20 load-use cycles
        IDEXmemread = 1'b1; IDEXRt = 5'd7; IFIDRs = 5'd7;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat4_cnt", 32'(stall_cnt4), 32'd15);
        chk("wide_cnt", 32'(stall_cnt), 32'd20);
        @(posedge clk); #1;
        chk("sat4_hold", 32'(stall_cnt4), 32'd15);
        chk("sat4_pc", 32'(pcwrite4), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
